// File: rtl/proj_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : proj_mem_reader
// Brief    : Streams projection-memory word pairs {odd, even} through a
//            2-entry pair FIFO with a valid/ready handshake.
//            Optional macro PROJ_READER_LOOP_EN adds the 'loop' input.
// Revision : 1.0 - initial release
// ============================================================================
module proj_mem_reader #(
  parameter int Dhv_SIZE   = 4000,
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     write_done,
`ifdef PROJ_READER_LOOP_EN
  input  logic                     loop,
`endif
  output logic [ADDR_WIDTH-1:0]    read_address0,
  output logic [ADDR_WIDTH-1:0]    read_address1,
  output logic                     re,
  input  logic [IN_WIDTH-1:0]      mem_out0,
  input  logic [IN_WIDTH-1:0]      mem_out1,
  output logic [1:0][IN_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int NUM_WORDS = Dhv_SIZE / IN_WIDTH;
  localparam int NUM_PAIRS = NUM_WORDS / 2;
  localparam logic [ADDR_WIDTH-1:0] c_last_k = ADDR_WIDTH'(NUM_PAIRS - 1);

  generate
    if ((NUM_WORDS % 2 != 0) || (NUM_WORDS > (1 << ADDR_WIDTH))) begin : g_bad_cfg
      $fatal(1, "proj_mem_reader: NUM_WORDS must be even and fit in ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_WR = 3'd1,
    S_STREAM  = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_clear;

  logic [ADDR_WIDTH-1:0]     r_k;
  logic [ADDR_WIDTH-1:0]     r_addr0;
  logic [ADDR_WIDTH-1:0]     r_addr1;
  logic                      r_rvalid;
  logic                      r_rlast;

  logic [1:0][IN_WIDTH-1:0]  r_fifo_data [2];
  logic                      r_fifo_last [2];
  logic                      r_wptr;
  logic                      r_rptr;
  logic [1:0]                r_count;

  logic                      w_pop;
  logic                      w_push;
  logic [2:0]                w_occ;
  logic                      w_issue;
  logic                      w_last_issue;
  logic [ADDR_WIDTH-1:0]     w_a0;
  logic [ADDR_WIDTH-1:0]     w_a1;

  // Pairs already committed (buffered or returning) after this edge, excluding a new issue.
  assign w_pop        = out_valid & out_ready;
  assign w_push       = r_rvalid;
  assign w_occ        = 3'(r_count) + 3'(r_rvalid) - 3'(w_pop);
  assign w_issue      = (r_state == S_STREAM) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_k == c_last_k);
  assign w_a0         = {r_k[ADDR_WIDTH-2:0], 1'b0};
  assign w_a1         = {r_k[ADDR_WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = write_done ? S_STREAM : S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        if (write_done) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_issue) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_count == 2'd0) && !r_rvalid) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
`ifdef PROJ_READER_LOOP_EN
        if (loop) begin
          w_clear = 1'b1;
          w_next  = S_STREAM;
        end else begin
          w_next  = S_IDLE;
        end
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pair counter and last-issued address registers; the outputs hold between issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k      <= '0;
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      r_rvalid <= w_issue;
      r_rlast  <= w_last_issue;
      if (w_clear) begin
        r_k     <= '0;
        r_addr0 <= '0;
        r_addr1 <= '0;
      end else if (w_issue) begin
        r_k     <= r_k + ADDR_WIDTH'(1);
        r_addr0 <= w_a0;
        r_addr1 <= w_a1;
      end
    end
  end

  // When full, push and pop share a slot: the head is consumed as it is overwritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= {mem_out1, mem_out0};
        r_fifo_last[r_wptr] <= r_rlast;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign re            = w_issue;
  assign read_address0 = w_issue ? w_a0 : r_addr0;
  assign read_address1 = w_issue ? w_a1 : r_addr1;
  assign out_valid     = (r_count != 2'd0);
  assign out_data      = r_fifo_data[r_rptr];
  assign out_last      = out_valid & r_fifo_last[r_rptr];
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire
